pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage RV32 pipeline (IF/ID/EX/MEM/WB).

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 36 +++
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 16 +
 rtl/pipeline_hazard_ctrl.sv | 119 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM encoding, per-stage
// control bundle and the register hazard compare.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_bubble;
    logic ex_mem_en;
    logic mem_wb_en;
  } ctl_t;

  // Field order: pc, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem, mem_wb
  localparam ctl_t CTL_IDLE  = ctl_t'(7'b0000000);
  localparam ctl_t CTL_RESET = ctl_t'(7'b0010100);
  localparam ctl_t CTL_HOLD  = ctl_t'(7'b0001111);
  localparam ctl_t CTL_FLUSH = ctl_t'(7'b1111011);
  localparam ctl_t CTL_RUN   = ctl_t'(7'b1101011);

  function automatic logic reg_hit(input logic [4:0] rd, input logic [4:0] rs,
                                   input logic use_rs);
    return use_rs && (rd == rs) && (rd != REG_X0);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating event counter with asynchronous active-high clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr)                     count <= '0;
    else if (en && count != '1)  count <= count + 1'b1;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges freeze, hazard stalls,
// redirects and halt into per-stage enables, with drain/halt FSM and perf counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int DRAIN_CYC = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_wait,
  input  logic             dec_redirect,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic             dec_use_rs1,
  input  logic             dec_use_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             halt_req,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_bubble,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             halted,
  output logic             proto_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] freeze_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int DRN_W = $clog2(DRAIN_CYC + 1);

  state_e           state, state_nxt;
  logic [DRN_W-1:0] drain_cnt, drain_nxt;
  ctl_t             ctl;
  logic             freeze, loaduse, stall;
  logic             perr_set, inc_stall, inc_freeze, inc_flush;

  assign freeze  = dmem_req & ~dmem_ready;
  assign loaduse = ex_mem_read & (reg_hit(ex_rd, dec_rs1, dec_use_rs1) |
                                  reg_hit(ex_rd, dec_rs2, dec_use_rs2));
  assign stall   = loaduse | dec_wait;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
      if (perr_set) proto_err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    drain_nxt  = drain_cnt;
    ctl        = CTL_RUN;
    perr_set   = 1'b0;
    inc_stall  = 1'b0;
    inc_freeze = 1'b0;
    inc_flush  = 1'b0;
    unique case (state)
      ST_HALT: ctl = CTL_IDLE;
      ST_DRAIN: begin
        if (freeze) begin
          ctl        = CTL_IDLE;
          inc_freeze = 1'b1;
        end else begin
          ctl       = CTL_HOLD;
          drain_nxt = drain_cnt - 1'b1;
          if (drain_cnt <= DRN_W'(1)) state_nxt = ST_HALT;
        end
      end
      default: begin  // ST_RUN, ST_STALL
        if (freeze) begin
          ctl        = CTL_IDLE;
          inc_freeze = 1'b1;
        end else if (stall) begin
          // a redirect seen here is dropped; decode re-presents it
          ctl       = CTL_HOLD;
          inc_stall = 1'b1;
          perr_set  = (state == ST_STALL) & dec_wait;
          state_nxt = ST_STALL;
        end else if (dec_redirect) begin
          ctl       = CTL_FLUSH;
          inc_flush = 1'b1;
          state_nxt = ST_RUN;
        end else if (halt_req && state == ST_RUN) begin
          drain_nxt = DRN_W'(DRAIN_CYC);
          state_nxt = ST_DRAIN;
        end else begin
          state_nxt = ST_RUN;
        end
      end
    endcase
    if (rst) ctl = CTL_RESET;
  end

  assign pc_en        = ctl.pc_en;
  assign if_id_en     = ctl.if_id_en;
  assign if_id_flush  = ctl.if_id_flush;
  assign id_ex_en     = ctl.id_ex_en;
  assign id_ex_bubble = ctl.id_ex_bubble;
  assign ex_mem_en    = ctl.ex_mem_en;
  assign mem_wb_en    = ctl.mem_wb_en;
  assign halted       = (state == ST_HALT);

  sat_counter #(.W(CNT_W)) u_stall_cnt  (.clk(clk), .clr(rst), .en(inc_stall),  .count(stall_cnt));
  sat_counter #(.W(CNT_W)) u_freeze_cnt (.clk(clk), .clr(rst), .en(inc_freeze), .count(freeze_cnt));
  sat_counter #(.W(CNT_W)) u_flush_cnt  (.clk(clk), .clr(rst), .en(inc_flush),  .count(flush_cnt));

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic
// against a cycle-level behavioural model; a CNT_W=4 copy shares the stimulus.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0, rst = 1'b1;
  logic       dec_wait, dec_redirect, dec_use_rs1, dec_use_rs2, ex_mem_read;
  logic [4:0] dec_rs1, dec_rs2, ex_rd;
  logic       dmem_req, dmem_ready, halt_req;

  logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_en;
  logic        halted, proto_err;
  logic [15:0] stall_cnt, freeze_cnt, flush_cnt;
  logic        pc_en4, if_id_en4, if_id_flush4, id_ex_en4, id_ex_bubble4, ex_mem_en4, mem_wb_en4;
  logic        halted4, proto_err4;
  logic [3:0]  stall_cnt4, freeze_cnt4, flush_cnt4;

  pipeline_hazard_ctrl #(.CNT_W(16), .DRAIN_CYC(3)) dut (
    .clk(clk), .rst(rst), .dec_wait(dec_wait), .dec_redirect(dec_redirect),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .halt_req(halt_req), .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_bubble(id_ex_bubble), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .halted(halted), .proto_err(proto_err), .stall_cnt(stall_cnt), .freeze_cnt(freeze_cnt),
    .flush_cnt(flush_cnt));

  pipeline_hazard_ctrl #(.CNT_W(4), .DRAIN_CYC(3)) dut4 (
    .clk(clk), .rst(rst), .dec_wait(dec_wait), .dec_redirect(dec_redirect),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .halt_req(halt_req), .pc_en(pc_en4), .if_id_en(if_id_en4), .if_id_flush(if_id_flush4),
    .id_ex_en(id_ex_en4), .id_ex_bubble(id_ex_bubble4), .ex_mem_en(ex_mem_en4), .mem_wb_en(mem_wb_en4),
    .halted(halted4), .proto_err(proto_err4), .stall_cnt(stall_cnt4), .freeze_cnt(freeze_cnt4),
    .flush_cnt(flush_cnt4));

  always #5 clk = ~clk;

  logic [6:0] act, act4;
  assign act  = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_en};
  assign act4 = {pc_en4, if_id_en4, if_id_flush4, id_ex_en4, id_ex_bubble4, ex_mem_en4, mem_wb_en4};

  localparam logic [6:0] E_IDLE = 7'b0000000, E_RESET = 7'b0010100, E_HOLD = 7'b0001111,
                         E_FLUSH = 7'b1111011, E_RUN = 7'b1101011;

  int errors = 0, checks = 0;

  // Behavioural model: what the pipeline is doing, counted in plain integers
  typedef enum {K_RST, K_IDLE, K_FREEZE, K_DRAIN, K_STALL, K_FLUSH, K_HALTGO, K_RUN} kind_e;
  bit    m_halted, m_prev_stall, m_perr;
  int    m_drain, m_stall, m_freeze, m_flush;
  kind_e m_kind;
  logic [6:0] exp_ctl;

  function automatic int sat(input int v, input int w);
    return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
  endfunction

  task automatic begin_cycle();
    @(negedge clk);
    rst = 0; dec_wait = 0; dec_redirect = 0; dec_rs1 = 0; dec_rs2 = 0;
    dec_use_rs1 = 0; dec_use_rs2 = 0; ex_mem_read = 0; ex_rd = 0;
    dmem_req = 0; dmem_ready = 0; halt_req = 0;
  endtask

  task automatic settle();
    bit frz, lu;
    #1;
    frz = dmem_req && !dmem_ready;
    lu  = ex_mem_read && ex_rd != 0 &&
          ((ex_rd == dec_rs1 && dec_use_rs1) || (ex_rd == dec_rs2 && dec_use_rs2));
    if (rst) begin
      m_halted = 0; m_prev_stall = 0; m_perr = 0; m_drain = 0;
      m_stall = 0; m_freeze = 0; m_flush = 0;
      m_kind = K_RST; exp_ctl = E_RESET;
    end
    else if (m_halted)                    begin m_kind = K_IDLE;   exp_ctl = E_IDLE;  end
    else if (frz)                         begin m_kind = K_FREEZE; exp_ctl = E_IDLE;  end
    else if (m_drain > 0)                 begin m_kind = K_DRAIN;  exp_ctl = E_HOLD;  end
    else if (lu || dec_wait)              begin m_kind = K_STALL;  exp_ctl = E_HOLD;  end
    else if (dec_redirect)                begin m_kind = K_FLUSH;  exp_ctl = E_FLUSH; end
    else if (halt_req && !m_prev_stall)   begin m_kind = K_HALTGO; exp_ctl = E_RUN;   end
    else                                  begin m_kind = K_RUN;    exp_ctl = E_RUN;   end
  endtask

  task automatic tick();
    @(posedge clk);
    case (m_kind)
      K_FREEZE: m_freeze++;
      K_DRAIN:  begin m_drain--; if (m_drain == 0) m_halted = 1; end
      K_STALL:  begin m_stall++; if (m_prev_stall && dec_wait) m_perr = 1; m_prev_stall = 1; end
      K_FLUSH:  begin m_flush++; m_prev_stall = 0; end
      K_HALTGO: begin m_drain = 3; m_prev_stall = 0; end
      K_RUN:    m_prev_stall = 0;
      default: ;
    endcase
  endtask

  task automatic do_reset();
    begin_cycle(); rst = 1; settle(); tick();
  endtask

  task automatic test_reset();
    @(negedge clk); settle();
    checks++; if (act !== E_RESET) begin errors++; $display("FAIL reset_ctl: got %b want %b", act, E_RESET); end
    checks++; if (halted !== 0 || proto_err !== 0) begin errors++; $display("FAIL reset_flags: got h=%b p=%b want 0 0", halted, proto_err); end
    checks++; if ({stall_cnt, freeze_cnt, flush_cnt} !== 48'd0) begin errors++; $display("FAIL reset_cnt: got %h want 0", {stall_cnt, freeze_cnt, flush_cnt}); end
    tick();
    begin_cycle(); settle();
    checks++; if (act !== E_RUN) begin errors++; $display("FAIL first_run: got %b want %b", act, E_RUN); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    begin_cycle(); ex_mem_read = 1; ex_rd = 5; dec_rs2 = 5; dec_use_rs2 = 1; settle();
    checks++; if (act !== E_HOLD) begin errors++; $display("FAIL loaduse_ctl: got %b want %b", act, E_HOLD); end
    tick();
    begin_cycle(); settle();
    checks++; if (act !== E_RUN) begin errors++; $display("FAIL loaduse_after: got %b want %b", act, E_RUN); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL loaduse_cnt: got %0d want 1", stall_cnt); end
    tick();
  endtask

  task automatic test_x0();
    begin_cycle(); ex_mem_read = 1; ex_rd = 0; dec_rs1 = 0; dec_use_rs1 = 1; settle();
    checks++; if (act !== E_RUN) begin errors++; $display("FAIL x0_no_stall: got %b want %b", act, E_RUN); end
    tick();
  endtask

  task automatic test_freeze_redirect();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      begin_cycle(); dmem_req = 1; dec_redirect = 1; settle();
      checks++; if (act !== E_IDLE) begin errors++; $display("FAIL freeze_ctl[%0d]: got %b want %b", i, act, E_IDLE); end
      tick();
    end
    begin_cycle(); dmem_req = 1; dmem_ready = 1; dec_redirect = 1; settle();
    checks++; if (act !== E_FLUSH) begin errors++; $display("FAIL freeze_release: got %b want %b", act, E_FLUSH); end
    checks++; if (freeze_cnt !== 16'd4 || flush_cnt !== 16'd0) begin errors++; $display("FAIL freeze_cnt: got f=%0d fl=%0d want 4 0", freeze_cnt, flush_cnt); end
    tick();
    begin_cycle(); settle();
    checks++; if (flush_cnt !== 16'd1) begin errors++; $display("FAIL flush_cnt: got %0d want 1", flush_cnt); end
    tick();
  endtask

  task automatic test_wait();
    do_reset();
    begin_cycle(); dec_wait = 1; dec_redirect = 1; settle();
    checks++; if (act !== E_HOLD) begin errors++; $display("FAIL wait_redirect: got %b want %b", act, E_HOLD); end
    tick();
    begin_cycle(); dec_wait = 1; settle();
    checks++; if (act !== E_HOLD || flush_cnt !== 16'd0 || proto_err !== 1'b0) begin
      errors++; $display("FAIL wait_second: got %b fl=%0d p=%b want %b 0 0", act, flush_cnt, proto_err, E_HOLD); end
    tick();
    begin_cycle(); settle();
    checks++; if (proto_err !== 1'b1 || stall_cnt !== 16'd2 || act !== E_RUN) begin
      errors++; $display("FAIL proto_err: got p=%b st=%0d %b want 1 2 %b", proto_err, stall_cnt, act, E_RUN); end
    tick();
  endtask

  task automatic test_halt();
    logic [6:0] seq [7] = '{E_RUN, E_HOLD, E_IDLE, E_HOLD, E_HOLD, E_IDLE, E_IDLE};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      begin_cycle(); halt_req = 1; dmem_req = (i == 2 || i == 6); settle();
      checks++; if (act !== seq[i] || halted !== (i >= 5)) begin
        errors++; $display("FAIL halt_seq[%0d]: got %b h=%b want %b h=%b", i, act, halted, seq[i], i >= 5); end
      tick();
    end
    begin_cycle(); settle();
    checks++; if (freeze_cnt !== 16'd1 || halted !== 1'b1) begin errors++; $display("FAIL halt_freeze: got f=%0d h=%b want 1 1", freeze_cnt, halted); end
    tick();
  endtask

  task automatic test_rst_exit();
    begin_cycle(); rst = 1; settle();
    checks++; if (act !== E_RESET || halted !== 1'b0) begin errors++; $display("FAIL rst_exit: got %b h=%b want %b 0", act, halted, E_RESET); end
    tick();
    begin_cycle(); settle();
    checks++; if (act !== E_RUN || halted !== 0 || {stall_cnt, freeze_cnt, flush_cnt} !== 48'd0) begin
      errors++; $display("FAIL rst_run: got %b h=%b cnt=%h want %b 0 0", act, halted, {stall_cnt, freeze_cnt, flush_cnt}, E_RUN); end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      begin_cycle(); ex_mem_read = 1; ex_rd = 7; dec_rs1 = 7; dec_use_rs1 = 1; settle(); tick();
    end
    begin_cycle(); settle();
    checks++; if (stall_cnt4 !== 4'd15) begin errors++; $display("FAIL sat4: got %0d want 15", stall_cnt4); end
    checks++; if (stall_cnt !== 16'd20) begin errors++; $display("FAIL sat16: got %0d want 20", stall_cnt); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      begin_cycle();
      rst          = ($urandom_range(0, 99) < 2);
      dec_wait     = ($urandom_range(0, 99) < 10);
      dec_redirect = ($urandom_range(0, 99) < 20);
      ex_mem_read  = ($urandom_range(0, 99) < 35);
      ex_rd        = 5'($urandom_range(0, 3));
      dec_rs1      = 5'($urandom_range(0, 3));
      dec_rs2      = 5'($urandom_range(0, 3));
      dec_use_rs1  = 1'($urandom_range(0, 1));
      dec_use_rs2  = 1'($urandom_range(0, 1));
      dmem_req     = ($urandom_range(0, 99) < 30);
      dmem_ready   = 1'($urandom_range(0, 1));
      halt_req     = ($urandom_range(0, 99) < 4);
      settle();
      checks++; if (act !== exp_ctl || act4 !== exp_ctl) begin
        errors++; $display("FAIL rnd_ctl[%0d]: got %b/%b want %b", i, act, act4, exp_ctl); end
      checks++; if (halted !== (m_halted && !rst) || proto_err !== m_perr || halted4 !== halted || proto_err4 !== proto_err) begin
        errors++; $display("FAIL rnd_flags[%0d]: got h=%b p=%b want h=%b p=%b", i, halted, proto_err, m_halted && !rst, m_perr); end
      checks++; if (stall_cnt !== 16'(sat(m_stall, 16)) || freeze_cnt !== 16'(sat(m_freeze, 16)) || flush_cnt !== 16'(sat(m_flush, 16))) begin
        errors++; $display("FAIL rnd_cnt16[%0d]: got %0d %0d %0d want %0d %0d %0d", i, stall_cnt, freeze_cnt, flush_cnt, m_stall, m_freeze, m_flush); end
      checks++; if (stall_cnt4 !== 4'(sat(m_stall, 4)) || freeze_cnt4 !== 4'(sat(m_freeze, 4)) || flush_cnt4 !== 4'(sat(m_flush, 4))) begin
        errors++; $display("FAIL rnd_cnt4[%0d]: got %0d %0d %0d want %0d %0d %0d", i, stall_cnt4, freeze_cnt4, flush_cnt4,
                           sat(m_stall, 4), sat(m_freeze, 4), sat(m_flush, 4)); end
      tick();
    end
  endtask

  initial begin
    dec_wait = 0; dec_redirect = 0; dec_rs1 = 0; dec_rs2 = 0; dec_use_rs1 = 0; dec_use_rs2 = 0;
    ex_mem_read = 0; ex_rd = 0; dmem_req = 0; dmem_ready = 0; halt_req = 0;
    test_reset();
    test_load_use();
    test_x0();
    test_freeze_redirect();
    test_wait();
    test_halt();
    test_rst_exit();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
